avalon_keys_poller: RTL and testbench

- Avalon-MM read master that periodically polls a key PIO slave, the responder side of the same s1 interface.
- Issues a single-word read at a fixed interval and holds the last sampled key vector.
- Emits one-cycle press/release pulses per key.
- Sits between the key PIO slave and a hardware consumer, such as the bathysphere depth controller, so key handling needs no CPU polling.

---
 rtl/avalon_keys_poller_pkg.sv | 20 ++
 rtl/avalon_keys_poller_if.sv | 26 ++
 rtl/avalon_keys_poller_keys_edge_detect.sv | 85 ++++++++
 rtl/avalon_keys_poller.sv | 104 ++++++++++
 tb/tb_avalon_keys_poller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_keys_poller_pkg.sv
// avalon_keys_pkg: FSM state type, released-key constant and counter width
// helper shared by avalon_keys_poller and its edge detector.
package avalon_keys_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    UPDATE
  } poll_state_e;

  localparam int MAX_KEY_W = 32;

  localparam logic [MAX_KEY_W-1:0] KEY_RELEASED_DEFAULT = '1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_keys_poller_if.sv
// avalon_keys_poller_if: Avalon-MM read-only bus between the poller
// (master) and the key PIO data register (slave).
interface avalon_keys_poller_if #(
  parameter int ADDR_W = 2
);

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/avalon_keys_poller_keys_edge_detect.sv
// keys_edge_detect: holds the committed key vector and emits press/release
// pulses; AVALON_KEYS_POLLER_DEBOUNCE_EN adds a stability filter.
module keys_edge_detect
  import avalon_keys_pkg::*;
#(
  parameter int KEY_W = 4
`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_SAMPLES = 3
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_i,
  input  logic [KEY_W-1:0] raw_i,
  output logic [KEY_W-1:0] keys_state_o,
  output logic [KEY_W-1:0] press_o,
  output logic [KEY_W-1:0] release_o,
  output logic             valid_o
);

  localparam logic [KEY_W-1:0] KEYS_RST =
    KEY_RELEASED_DEFAULT[KEY_W-1:0];

  logic [KEY_W-1:0] keys_q;
  logic [KEY_W-1:0] press_q;
  logic [KEY_W-1:0] rel_q;
  logic             valid_q;
  logic             commit_d;

`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
  localparam int SCW = cnt_w(DEBOUNCE_SAMPLES + 1);

  logic [KEY_W-1:0] prev_q;
  logic [SCW-1:0]   stab_q;
  logic [SCW-1:0]   stab_d;

  // Run length of identical raw samples, saturating at the threshold.
  always_comb begin
    stab_d = stab_q;
    if (raw_i != prev_q) begin
      stab_d = SCW'(1);
    end else if (stab_q < SCW'(DEBOUNCE_SAMPLES)) begin
      stab_d = stab_q + 1'b1;
    end
    commit_d = update_i && (stab_d >= SCW'(DEBOUNCE_SAMPLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= KEYS_RST;
      stab_q <= '0;
    end else if (update_i) begin
      prev_q <= raw_i;
      stab_q <= stab_d;
    end
  end
`else
  always_comb begin
    commit_d = update_i;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_q  <= KEYS_RST;
      press_q <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= update_i;
      press_q <= commit_d ? (keys_q & ~raw_i) : '0;
      rel_q   <= commit_d ? (~keys_q & raw_i) : '0;
      if (commit_d) begin
        keys_q <= raw_i;
      end
    end
  end

  assign keys_state_o = keys_q;
  assign press_o      = press_q;
  assign release_o    = rel_q;
  assign valid_o      = valid_q;

endmodule

// File: rtl/avalon_keys_poller.sv
// avalon_keys_poller: periodic Avalon-MM poll of a key PIO register with
// press/release pulses; AVALON_KEYS_POLLER_DEBOUNCE_EN enables debouncing.
module avalon_keys_poller
  import avalon_keys_pkg::*;
#(
  parameter int POLL_PERIOD   = 50000,
  parameter int KEY_W         = 4,
  parameter int ADDR_W        = 2,
  parameter int DATA_REG_ADDR = 0,
  parameter int READ_LATENCY  = 1
`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_SAMPLES = 3
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 poll_en,
  avalon_keys_poller_if.master avm,
  output logic [KEY_W-1:0]     keys_state,
  output logic [KEY_W-1:0]     key_press,
  output logic [KEY_W-1:0]     key_release,
  output logic                 sample_valid
);

  localparam int PCW = cnt_w(POLL_PERIOD);
  localparam int LCW = cnt_w(READ_LATENCY);
  localparam logic [PCW-1:0] PCNT_RLD = PCW'(POLL_PERIOD - 1);
  localparam logic [LCW-1:0] LCNT_RLD = LCW'(READ_LATENCY - 1);

  poll_state_e      state_q;
  logic [PCW-1:0]   pcnt_q;
  logic [LCW-1:0]   lcnt_q;
  logic             read_q;
  logic [KEY_W-1:0] raw_q;
  logic             unused_hi;

  // Upper readdata bits carry nothing for this block.
  assign unused_hi = ^avm.avm_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= PCNT_RLD;
      lcnt_q  <= '0;
      read_q  <= 1'b0;
      raw_q   <= KEY_RELEASED_DEFAULT[KEY_W-1:0];
    end else begin
      unique case (state_q)
        IDLE: begin
          if (poll_en) begin
            if (pcnt_q == '0) begin
              state_q <= REQ;
              read_q  <= 1'b1;
            end else begin
              pcnt_q <= pcnt_q - 1'b1;
            end
          end
        end
        REQ: begin
          if (!avm.avm_waitrequest) begin
            state_q <= WAIT;
            read_q  <= 1'b0;
            lcnt_q  <= LCNT_RLD;
          end
        end
        WAIT: begin
          if (lcnt_q == '0) begin
            state_q <= UPDATE;
            raw_q   <= avm.avm_readdata[KEY_W-1:0];
          end else begin
            lcnt_q <= lcnt_q - 1'b1;
          end
        end
        UPDATE: begin
          state_q <= IDLE;
          pcnt_q  <= PCNT_RLD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm.avm_address = ADDR_W'(DATA_REG_ADDR);
  assign avm.avm_read    = read_q;

  keys_edge_detect #(
    .KEY_W(KEY_W)
`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
    ,
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
`endif
  ) u_edge (
    .clk         (clk),
    .reset       (reset),
    .update_i    (state_q == UPDATE),
    .raw_i       (raw_q),
    .keys_state_o(keys_state),
    .press_o     (key_press),
    .release_o   (key_release),
    .valid_o     (sample_valid)
  );

endmodule

// File: tb/tb_avalon_keys_poller.sv
// tb_avalon_keys_poller: directed and random polling against a timeline
// model of poll start, read acceptance and result landing.
module tb_avalon_keys_poller;

  localparam int P   = 4;
  localparam int KW  = 4;
  localparam int AW  = 2;
  localparam int DRA = 1;
  localparam int RL  = 2;
  localparam int DS  = 3;

  logic clk;
  logic reset;
  logic poll_en;
  logic [KW-1:0] keys_state;
  logic [KW-1:0] key_press;
  logic [KW-1:0] key_release;
  logic sample_valid;

  avalon_keys_poller_if #(.ADDR_W(AW)) bus ();

  avalon_keys_poller #(
    .POLL_PERIOD  (P),
    .KEY_W        (KW),
    .ADDR_W       (AW),
    .DATA_REG_ADDR(DRA),
    .READ_LATENCY (RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .poll_en     (poll_en),
    .avm         (bus),
    .keys_state  (keys_state),
    .key_press   (key_press),
    .key_release (key_release),
    .sample_valid(sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int samp_cyc = -1;
  int dut_acc = 0;
  logic [31:0] samp_word;
  logic [KW-1:0] poll_key;
  bit chk_en = 0;

  // Model state: expected outputs plus the poll timeline.
  logic [KW-1:0] m_keys, m_press, m_rel, land_key;
  logic m_read, m_sv;
  int idle_n, land;
  bit busy;
  logic [KW-1:0] hist[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic commit_model(input logic [KW-1:0] nk);
    bit ok;
    ok = 1;
`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
    hist.push_back(nk);
    if (hist.size() > DS) void'(hist.pop_front());
    ok = (hist.size() == DS);
    foreach (hist[i]) if (hist[i] != nk) ok = 0;
`endif
    if (ok) begin
      m_press = m_keys & ~nk;
      m_rel   = ~m_keys & nk;
      m_keys  = nk;
    end
  endtask

  // Timeline model: a read starts after P enabled idle cycles, the word
  // is on the bus RL cycles after acceptance, results show RL+2 later.
  always @(posedge clk) begin
    int p;
    p = cyc;
    cyc = cyc + 1;
    if (!reset && bus.avm_read && !bus.avm_waitrequest) dut_acc++;
    if (reset) begin
      m_keys = '1; m_press = '0; m_rel = '0;
      m_sv = 0; m_read = 0;
      idle_n = 0; busy = 0; land = -1;
      hist.delete();
    end else begin
      m_sv = 0; m_press = '0; m_rel = '0;
      if (m_read) begin
        if (!bus.avm_waitrequest) begin
          m_read = 0;
          land = p + RL + 2;
          land_key = poll_key;
          samp_word = $urandom;
          samp_word[KW-1:0] = poll_key;
          samp_cyc = p + RL;
        end
      end else if (!busy && poll_en) begin
        idle_n++;
        if (idle_n == P) begin
          m_read = 1; busy = 1; idle_n = 0;
        end
      end
      if (busy && land == cyc) begin
        busy = 0;
        m_sv = 1;
        commit_model(land_key);
      end
    end
  end

  // Slave: valid word only in the data cycle, junk otherwise.
  always @(negedge clk) begin
    if (cyc == samp_cyc) bus.avm_readdata = samp_word;
    else bus.avm_readdata = $urandom;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("avm_read", bus.avm_read, m_read);
      check("avm_address", bus.avm_address, DRA);
      check("keys_state", keys_state, m_keys);
      check("key_press", key_press, m_press);
      check("key_release", key_release, m_rel);
      check("sample_valid", sample_valid, m_sv);
      check("press_and_release", key_press & key_release, 0);
    end
  end

  task automatic wait_read(output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (bus.avm_read !== 1'b1 && n < 40);
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (sample_valid !== 1'b1 && n < 40);
  endtask

`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
  logic [KW-1:0] seq [5] = '{4'hE, 4'hF, 4'hE, 4'hE, 4'hE};
`endif

  initial begin
    int n, a0;
    reset = 1; poll_en = 1; poll_key = 4'hF;
    bus.avm_waitrequest = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_keys", keys_state, 4'hF);
    check("rst_read", bus.avm_read, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_press", key_press, 0);
    reset = 0;

    wait_read(n);
    check("first_req_delay", n, 4);
    wait_sv(n);
    check("sv_latency", n, RL + 2);
    check("first_keys", keys_state, 4'hF);
    check("first_no_press", key_press, 0);
    check("first_no_release", key_release, 0);

`ifdef AVALON_KEYS_POLLER_DEBOUNCE_EN
    for (int i = 0; i < 5; i++) begin
      poll_key = seq[i];
      wait_sv(n);
      check("db_press", key_press, (i == 4) ? 4'h1 : 4'h0);
    end
    poll_key = 4'hF;
    repeat (3) wait_sv(n);
    check("db_restore", keys_state, 4'hF);
`else
    poll_key = 4'hE;
    wait_sv(n);
    check("press_e", key_press, 4'h1);
    check("keys_e", keys_state, 4'hE);
    poll_key = 4'hF;
    wait_sv(n);
    check("release_f", key_release, 4'h1);
    check("release_no_press", key_press, 0);
    check("keys_f", keys_state, 4'hF);
`endif

    bus.avm_waitrequest = 1;
    wait_read(n);
    check("period_gap", n, P);
    a0 = dut_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wr_hold_read", bus.avm_read, 1);
      check("wr_hold_addr", bus.avm_address, DRA);
    end
    bus.avm_waitrequest = 0;
    @(negedge clk);
    check("wr_released", bus.avm_read, 0);
    check("one_accept", dut_acc - a0, 1);

    poll_en = 0;
    wait_sv(n);
    check("sv_after_drop", n, RL + 1);
    repeat (10) @(negedge clk);
    check("hold_no_read", bus.avm_read, 0);
    poll_key = 4'h0;
    poll_en = 1;
    wait_read(n);
    check("resume_delay", n, P);

    @(negedge clk);
    reset = 1; poll_en = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_wait_sv", sample_valid, 0);
      check("rst_wait_keys", keys_state, 4'hF);
      check("rst_wait_press", key_press, 0);
    end
    poll_en = 1;
    poll_key = 4'hF;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      poll_en = ($urandom_range(0, 7) != 0);
      bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      poll_key = KW'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
